hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer that owns all writes into the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a 32-iteration shift-add or restoring-divide datapath.
- Holds the pipeline via stallreq while it runs.
- Issues a one-cycle HI/LO write whose fields feed the HI/LO write bus and the EX→ID forwarding bus.

Parameters:
DATA_W, 32, operand and HI/LO width; the iteration count equals DATA_W.

Ports:
clk  in  1  system clock, rising edge.
resetn  in  1  asynchronous active-low reset.
start  in  1  EX presents a valid HI/LO op this cycle.
op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (ignored).
src_a  in  DATA_W  rs value; multiplicand, dividend, or MTHI/MTLO data.
src_b  in  DATA_W  rt value; multiplier or divisor.
flush  in  1  pipeline flush; aborts any op in flight.
stallreq  out  1  pipeline hold request.
busy  out  1  FSM not in IDLE.
done  out  1  one-cycle completion pulse.
hi_we  out  1  HI write enable, one-cycle pulse.
lo_we  out  1  LO write enable, one-cycle pulse.
hi_o  out  DATA_W  HI write data.
lo_o  out  DATA_W  LO write data.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State goes to IDLE; counter, accumulators and all outputs clear to 0.
  - Reset asserted mid-operation discards the op with no write.
- FSM states: IDLE, RUN, FIX, DONE.
- Start is sampled only in IDLE; call the sampling cycle T. Start seen in any other state is ignored, and EX is already held by stallreq.
- IDLE, start with MUL/DIV op, divisor ≠ 0 (or a multiply op):
  - Latch the operand magnitudes (signed ops take |x|).
  - Latch the result signs: product sign a^b; quotient sign a^b; remainder sign = sign(a).
  - cnt←0, go to RUN.
  - stallreq=1 combinationally in cycle T.
- RUN, cycles T+1..T+32, one iteration per cycle:
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring step on a 2·DATA_W-bit partial remainder.
  - cnt increments; after cnt=31 go to FIX.
- FIX (T+33): apply two's-complement sign correction; register hi_o/lo_o; go to DONE.
- DONE (T+34):
  - hi_we=lo_we=done=1 for exactly one cycle; hi_o/lo_o valid.
  - stallreq=0; return to IDLE.
- stallreq=1 throughout T..T+33.
- Results:
  - MULT/MULTU: {hi,lo} = full 64-bit product.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - Signed 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (natural magnitude result, no trap).
- Divide by zero (DIV/DIVU, src_b=0):
  - No iteration; go straight to DONE at T+1.
  - done=1 with hi_we=lo_we=0, so HI/LO are unchanged.
  - stallreq=0 at T.
- MTHI/MTLO:
  - No stall; go to DONE at T+1.
  - MTHI: hi_we=1, hi_o=src_a, lo_we=0. MTLO is the mirror.
- op 000/111 with start: no action, remains IDLE.
- flush:
  - In any state, next state = IDLE; hi_we/lo_we/done forced 0 in the flush cycle and after.
  - stallreq=0 from the flush cycle onward.
  - flush together with start in IDLE: start ignored.
- hi_o/lo_o hold their last value outside the DONE cycle; consumers qualify them with hi_we/lo_we.

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=0x00000003 at T → stallreq=1 T..T+33; at T+34: hi_we=lo_we=done=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
- DIVU 100/7 → T+34: lo_o=14, hi_o=2.
- DIV 0xFFFFFFF9/2 → T+34: lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIVU src_b=0 → stallreq never high; done=1 at T+1 with hi_we=lo_we=0.
- MTHI src_a=0x1234 → T+1: hi_we=1, hi_o=0x1234, lo_we=0, stallreq never high.
- MULT started at T, flush at T+10 → busy=0 at T+11, no hi_we/lo_we ever; new DIVU accepted at T+12 completes at T+46.
- resetn=0 at T+5 of a DIV → all outputs 0 immediately; after release, state is IDLE and no write occurs.
- start asserted again at T+3 during a MULT → ignored; exactly one DONE pulse at T+34.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning all HI/LO writes
// Inputs: clk, resetn (async, active-low), start/op/src_a/src_b from EX, flush.
// Outputs: stallreq (pipeline hold), busy, done pulse, hi_we/lo_we pulses, hi_o/lo_o write data.
module hilo_muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              stallreq,
  output logic              busy,
  output logic              done,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d, acc_neg;
  logic [DATA_W-1:0] m_q, m_d, hi_o_q, hi_o_d, lo_o_q, lo_o_d, abs_a, abs_b, diff;
  logic div_q, div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d;
  logic hi_we_q, hi_we_d, lo_we_q, lo_we_d, done_q, done_d;
  logic sgn, is_mul, is_div, long_op, ge;
  logic [DATA_W:0] msum, top;
  assign sgn = op == 3'd1 || op == 3'd3;
  assign is_mul = op == 3'd1 || op == 3'd2;
  assign is_div = op == 3'd3 || op == 3'd4;
  assign long_op = is_mul || (is_div && src_b != '0);
  assign abs_a = sgn && src_a[DATA_W-1] ? -src_a : src_a;
  assign abs_b = sgn && src_b[DATA_W-1] ? -src_b : src_b;
  // multiply: acc = {partial product, remaining multiplier bits}, add then shift right
  assign msum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, acc_q[0] ? m_q : {DATA_W{1'b0}}};
  // divide: acc = {partial remainder, remaining dividend / quotient bits}; top keeps the bit shifted out
  assign top = acc_q[2*DATA_W-1:DATA_W-1];
  assign ge = top >= {1'b0, m_q};
  assign diff = top[DATA_W-1:0] - m_q;
  assign acc_neg = -acc_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    m_d = m_q;
    div_d = div_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    hi_o_d = hi_o_q;
    lo_o_d = lo_o_q;
    hi_we_d = 1'b0;
    lo_we_d = 1'b0;
    done_d = 1'b0;
    if (flush) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        if (long_op) begin
          state_d = RUN;
          cnt_d = '0;
          div_d = is_div;
          m_d = is_div ? abs_b : abs_a;
          acc_d = {{DATA_W{1'b0}}, is_div ? abs_a : abs_b};
          neg_p_d = sgn && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
          neg_r_d = sgn && src_a[DATA_W-1];
        end else if (is_div || op == 3'd5 || op == 3'd6) begin
          state_d = DONE;
          done_d = 1'b1;
          hi_we_d = op == 3'd5;
          lo_we_d = op == 3'd6;
          hi_o_d = op == 3'd5 ? src_a : hi_o_q;
          lo_o_d = op == 3'd6 ? src_a : lo_o_q;
        end
      end
      RUN: begin
        acc_d = div_q ? {ge ? diff : top[DATA_W-1:0], acc_q[DATA_W-2:0], ge} : {msum, acc_q[DATA_W-1:1]};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(DATA_W-1) ? FIX : RUN;
      end
      FIX: begin
        hi_o_d = div_q ? (neg_r_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W])
                       : (neg_p_q ? acc_neg[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W]);
        lo_o_d = neg_p_q ? acc_neg[DATA_W-1:0] : acc_q[DATA_W-1:0];
        hi_we_d = 1'b1;
        lo_we_d = 1'b1;
        done_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      m_q <= '0;
      div_q <= 1'b0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_o_q <= '0;
      lo_o_q <= '0;
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      m_q <= m_d;
      div_q <= div_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      hi_o_q <= hi_o_d;
      lo_o_q <= lo_o_d;
      hi_we_q <= hi_we_d;
      lo_we_q <= lo_we_d;
      done_q <= done_d;
    end
  end
  // stall is raised combinationally in the accept cycle so EX holds before RUN starts
  assign stallreq = resetn && !flush &&
                    ((state_q == IDLE && start && long_op) || state_q == RUN || state_q == FIX);
  assign busy = state_q != IDLE;
  assign done = done_q && !flush;
  assign hi_we = hi_we_q && !flush;
  assign lo_we = lo_we_q && !flush;
  assign hi_o = hi_o_q;
  assign lo_o = lo_o_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed and random checks of hilo_muldiv_ctrl against an arithmetic reference
module tb_hilo_muldiv_ctrl;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic stallreq, busy, done, hi_we, lo_we;
  logic [31:0] hi_o, lo_o;
  logic [31:0] hi_m = '0, lo_m = '0;
  int passed = 0, total = 0;
  hilo_muldiv_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stallreq(stallreq), .busy(busy), .done(done), .hi_we(hi_we),
    .lo_we(lo_we), .hi_o(hi_o), .lo_o(lo_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: return 64'(sa * sb);
      3'd2: return {32'b0, a} * {32'b0, b};
      3'd3: return {32'(sa % sb), 32'(sa / sb)};
      3'd4: return {a % b, a / b};
      default: return '0;
    endcase
  endfunction
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit restart);
    logic [63:0] r;
    logic [1:0] exp_we;
    bit lng, st_ok;
    int lat, exp_lat;
    lng = (o == 3'd1 || o == 3'd2) || ((o == 3'd3 || o == 3'd4) && b != 0);
    exp_lat = lng ? 34 : 1;
    exp_we = lng ? 2'b11 : (o == 3'd5 ? 2'b10 : (o == 3'd6 ? 2'b01 : 2'b00));
    r = lng ? ref_res(o, a, b) : '0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    chk("stall_T", 64'(stallreq), 64'(lng));
    @(negedge clk);
    start = 1'b0; op = 3'd0; src_a = $urandom; src_b = $urandom;
    lat = 1;
    st_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      st_ok = st_ok && stallreq === 1'b1 && hi_we === 1'b0 && lo_we === 1'b0;
      start = restart && lat == 3;
      op = start ? 3'd2 : 3'd0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (lng) {hi_m, lo_m} = r;
    else if (o == 3'd5) hi_m = a;
    else if (o == 3'd6) lo_m = a;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("stall_run", 64'(st_ok), 64'd1);
    chk("stall_done", 64'(stallreq), 64'd0);
    chk("we", 64'({hi_we, lo_we}), 64'(exp_we));
    chk("hi", 64'(hi_o), 64'(hi_m));
    chk("lo", 64'(lo_o), 64'(lo_m));
    @(negedge clk);
    chk("one_pulse", 64'({busy, done, hi_we, lo_we}), 64'd0);
  endtask
  initial begin
    logic [3:0] seen;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({stallreq, busy, done, hi_we, lo_we}), 64'd0);
    chk("reset_data", {hi_o, lo_o}, 64'd0);
    resetn = 1'b1;
    run_op(3'd1, 32'hFFFFFFFE, 32'h00000003, 1'b0);
    run_op(3'd4, 32'd100, 32'd7, 1'b0);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(3'd4, 32'd123, 32'd0, 1'b0);
    run_op(3'd3, 32'hFFFFFFFB, 32'd0, 1'b0);
    run_op(3'd5, 32'h00001234, 32'd0, 1'b0);
    run_op(3'd6, 32'hCAFEF00D, 32'd9, 1'b0);
    run_op(3'd1, 32'h89ABCDEF, 32'h7654321F, 1'b1);
    // reserved and none opcodes do nothing
    @(negedge clk);
    start = 1'b1; op = 3'd7; src_a = $urandom; src_b = $urandom;
    #1;
    chk("op7_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    op = 3'd0;
    chk("op7_idle", 64'({busy, done, hi_we, lo_we}), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("op0_idle", 64'({busy, done, hi_we, lo_we}), 64'd0);
    // flush together with start in IDLE
    start = 1'b1; op = 3'd1; flush = 1'b1;
    #1;
    chk("flush_start_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    start = 1'b0; op = 3'd0; flush = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd0);
    // flush at T+10 of a MULT, then a DIVU accepted at T+12
    start = 1'b1; op = 3'd1; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    seen = '0;
    repeat (9) begin
      seen = seen | {1'b0, hi_we, lo_we, done};
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    chk("flush_stall", 64'(stallreq), 64'd0);
    chk("flush_nowrite", 64'({seen, hi_we, lo_we, done}), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    run_op(3'd4, $urandom, 32'd13, 1'b0);
    // async reset at T+5 of a DIV
    @(negedge clk);
    start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_ctl", 64'({stallreq, busy, done, hi_we, lo_we}), 64'd0);
    chk("rst_data", {hi_o, lo_o}, 64'd0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    resetn = 1'b1;
    seen = '0;
    repeat (40) begin
      seen = seen | {busy, done, hi_we, lo_we};
      @(negedge clk);
    end
    chk("rst_nowrite", 64'(seen), 64'd0);
    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      logic [31:0] a, b;
      o = 3'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = $urandom_range(1, 20);
        2: a = 32'h80000000;
        default: ;
      endcase
      run_op(o, a, b, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
